char_lcd_seq: RTL and testbench

Sequencer for the character-LCD path. It generates the 9-bit `lcd_cnt` step index consumed by the LCD command/character decoder. It enforces power-up delay, per-step dwell time, the extended Display Clear execution time, and refresh framing. It sits between the system clock domain and the decoder; the decoder derives `lcd_e = lcd_cnt[0]` and `lcd_state = lcd_cnt[8:1]`.

---
 rtl/char_lcd_pkg.sv | 25 ++
 rtl/char_lcd_seq_dwell_timer.sv | 28 ++
 rtl/char_lcd_seq.sv | 113 +++++++++++
 tb/tb_char_lcd_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/char_lcd_pkg.sv
// Shared types and constants for the character-LCD sequencer and its decoder.
// The decoder sees lcd_e = lcd_cnt[0] and lcd_state = lcd_cnt[8:1].
package char_lcd_pkg;

  localparam int LCD_CNT_W = 9;

  typedef logic [LCD_CNT_W-1:0] lcd_cnt_t;

  typedef enum logic [1:0] {
    PWRUP = 2'd0,
    RUN   = 2'd1,
    IDLE  = 2'd2
  } lcd_state_t;

  localparam lcd_cnt_t CNT_ZERO     = 9'h000;
  localparam lcd_cnt_t CNT_CLR_WAIT = 9'h006;
  localparam lcd_cnt_t CNT_HOME     = 9'h00A;
  localparam lcd_cnt_t CNT_LAST     = 9'h04D;
  localparam lcd_cnt_t CNT_PARK     = 9'h04E;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/char_lcd_seq_dwell_timer.sv
// Dwell timer: counts cycles up to a loadable terminal count, pulses o_expire on
// the last cycle of the dwell and restarts from zero; i_clear holds it at zero.
module lcd_dwell_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [CNT_W:0]   i_term,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  // Terminal count is one bit wider so a power-of-two dwell still fits.
  assign w_hit    = ({1'b0, r_cnt} == (i_term - (CNT_W+1)'(1)));
  assign o_expire = w_hit & ~i_clear;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/char_lcd_seq.sv
// Character-LCD step sequencer: power-up wait, per-step dwell with a long hold
// after Display Clear, one init frame, then refresh frames on request.
module char_lcd_seq
  import char_lcd_pkg::*;
#(
  parameter int STEP_CYC  = 50_000,
  parameter int PWRUP_CYC = 2_000_000,
  parameter int CLR_CYC   = 100_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 auto_refresh,
  output logic [LCD_CNT_W-1:0] lcd_cnt,
  output logic                 busy,
  output logic                 init_done,
  output logic                 frame_done
);

  localparam int DW = $clog2(max_int(PWRUP_CYC, STEP_CYC + CLR_CYC));
  localparam int TW = DW + 1;

  localparam logic [TW-1:0] TERM_PWRUP = TW'(PWRUP_CYC);
  localparam logic [TW-1:0] TERM_STEP  = TW'(STEP_CYC);
  localparam logic [TW-1:0] TERM_CLR   = TW'(STEP_CYC + CLR_CYC);

  lcd_state_t r_state, w_state_next;
  lcd_cnt_t   r_lcd_cnt, w_lcd_cnt_next;
  logic       r_busy, w_busy_next;
  logic       r_init_done, w_init_done_next;
  logic       r_frame_done, w_frame_done_next;

  logic          w_clear;
  logic          w_expire;
  logic [TW-1:0] w_term;

  // Dwell length depends only on registered state, never on this cycle's expire.
  assign w_term = (r_state == PWRUP)                                 ? TERM_PWRUP :
                  (r_state == RUN && r_lcd_cnt == CNT_CLR_WAIT)      ? TERM_CLR   :
                                                                       TERM_STEP;
  assign w_clear = (r_state == IDLE);

  lcd_dwell_timer #(
    .CNT_W (DW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_term   (w_term),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next      = r_state;
    w_lcd_cnt_next    = r_lcd_cnt;
    w_init_done_next  = r_init_done;
    w_frame_done_next = 1'b0;
    case (r_state)
      PWRUP: begin
        w_lcd_cnt_next = CNT_ZERO;
        if (w_expire) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_expire) begin
          if (r_lcd_cnt == CNT_LAST) begin
            w_lcd_cnt_next    = CNT_PARK;
            w_frame_done_next = 1'b1;
            w_init_done_next  = 1'b1;
            w_state_next      = IDLE;
          end else begin
            w_lcd_cnt_next = r_lcd_cnt + 9'd1;
          end
        end
      end
      IDLE: begin
        w_lcd_cnt_next = CNT_PARK;
        if (start || auto_refresh) begin
          w_lcd_cnt_next = CNT_HOME;
          w_state_next   = RUN;
        end
      end
      default: begin
        w_lcd_cnt_next = CNT_ZERO;
        w_state_next   = PWRUP;
      end
    endcase
    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= PWRUP;
      r_lcd_cnt    <= CNT_ZERO;
      r_busy       <= 1'b1;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lcd_cnt    <= w_lcd_cnt_next;
      r_busy       <= w_busy_next;
      r_init_done  <= w_init_done_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign lcd_cnt    = r_lcd_cnt;
  assign busy       = r_busy;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_char_lcd_seq.sv
// Scoreboard bench for char_lcd_seq: every change of the output bundle is a
// transaction, checked against a queue of expected (cycle, outputs) entries.
module tb_char_lcd_seq;
  import char_lcd_pkg::*;

  localparam int STEP = 4;
  localparam int PWR  = 10;
  localparam int CLR  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       auto_refresh = 1'b0;
  logic [8:0] lcd_cnt;
  logic       busy, init_done, frame_done;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         t;
    logic [8:0] cnt;
    logic       busy;
    logic       ini;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  char_lcd_seq #(
    .STEP_CYC  (STEP),
    .PWRUP_CYC (PWR),
    .CLR_CYC   (CLR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .auto_refresh (auto_refresh),
    .lcd_cnt      (lcd_cnt),
    .busy         (busy),
    .init_done    (init_done),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int t, input logic [8:0] c, input logic b, input logic i, input logic f);
    exp_t e;
    e.t = t; e.cnt = c; e.busy = b; e.ini = i; e.fd = f;
    exp_q.push_back(e);
  endtask

  // Expected value changes of one frame entered at t_entry; entries past stop are not pushed.
  task automatic push_frame(input int t_entry, input int first, input int stop, input logic ini, input int frame_len);
    int t;
    t = t_entry;
    for (int v = first; v < int'(CNT_LAST); v++) begin
      t += (v == 6) ? STEP + CLR : STEP;
      if (v + 1 > stop) return;
      push(t, 9'(v + 1), 1'b1, ini, 1'b0);
    end
    push(t_entry + frame_len, CNT_PARK, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor
  logic [11:0] prev = 'x;
  always @(negedge clk) begin
    logic [11:0] cur;
    exp_t        e;
    cur = {lcd_cnt, busy, init_done, frame_done};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_txn t=%0d got lcd_cnt=%h busy=%b init=%b fd=%b, required no change",
                 cyc, lcd_cnt, busy, init_done, frame_done);
      end else begin
        e = exp_q.pop_front();
        if (e.t != cyc || cur !== {e.cnt, e.busy, e.ini, e.fd}) begin
          failures++;
          $display("FAIL txn got t=%0d lcd_cnt=%h busy=%b init=%b fd=%b, required t=%0d lcd_cnt=%h busy=%b init=%b fd=%b",
                   cyc, lcd_cnt, busy, init_done, frame_done, e.t, e.cnt, e.busy, e.ini, e.fd);
        end else begin
          $display("txn t=%0d lcd_cnt=%h busy=%b init=%b fd=%b ok", cyc, lcd_cnt, busy, init_done, frame_done);
        end
      end
    end
    prev = cur;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0d, required end of stimulus", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel, e, a, f, g, rel2;

    // Reset state, power-up, init frame, start pulse dropped during PWRUP
    push(1, CNT_ZERO, 1'b1, 1'b0, 1'b0);
    wait_cyc(3);
    rst_n = 1'b1;
    rel = 3;
    push_frame(rel + PWR, 0, 511, 1'b0, 318);
    push(rel + 329, CNT_PARK, 1'b0, 1'b1, 1'b0);
    wait_cyc(5);  start = 1'b1;
    wait_cyc(6);  start = 1'b0;

    // Refresh frame on a single start pulse; second pulse at 0x020 is dropped
    wait_cyc(rel + 340);
    start = 1'b1;
    e = rel + 341;
    push(e, CNT_HOME, 1'b1, 1'b1, 1'b0);
    push_frame(e, 10, 511, 1'b1, 272);
    push(e + 273, CNT_PARK, 1'b0, 1'b1, 1'b0);
    wait_cyc(e);       start = 1'b0;
    wait_cyc(e + 90);  start = 1'b1;
    wait_cyc(e + 91);  start = 1'b0;

    // Auto refresh for three frames, one idle cycle between them
    a = e + 303;
    wait_cyc(a);
    auto_refresh = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int t;
      t = a + 1 + 273 * k;
      if (k == 0) push(t, CNT_HOME, 1'b1, 1'b1, 1'b0);
      push_frame(t, 10, 511, 1'b1, 272);
      if (k < 2) push(t + 273, CNT_HOME, 1'b1, 1'b1, 1'b0);
      else       push(t + 273, CNT_PARK, 1'b0, 1'b1, 1'b0);
    end
    f = a + 1 + 273 * 2 + 272;
    wait_cyc(f);
    auto_refresh = 1'b0;

    // start and auto_refresh together, then reset at lcd_cnt 0x030
    wait_cyc(f + 20);
    start = 1'b1;
    auto_refresh = 1'b1;
    g = f + 21;
    push(g, CNT_HOME, 1'b1, 1'b1, 1'b0);
    push_frame(g, 10, 'h30, 1'b1, 272);
    rel2 = g + 154;
    push(rel2, CNT_ZERO, 1'b1, 1'b0, 1'b0);
    push_frame(rel2 + PWR, 0, 511, 1'b0, 318);
    push(rel2 + 329, CNT_PARK, 1'b0, 1'b1, 1'b0);
    wait_cyc(g);
    start = 1'b0;
    auto_refresh = 1'b0;
    wait_cyc(g + 153);  rst_n = 1'b0;
    wait_cyc(g + 154);  rst_n = 1'b1;

    wait_cyc(rel2 + 360);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_txns got %0d outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
